// File: rtl/gpp16_pkg.sv
// Shared encodings for the GPP16 sequencer: opcodes, FSM states, ALU controls, IR field layout.
package gpp16_pkg;

    localparam int INSTR_W = 16;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 11;
    localparam int RD_MSB  = 10;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 5;
    localparam int RS2_MSB = 4;
    localparam int RS2_LSB = 2;

    typedef enum logic [4:0] {
        OPC_ADD = 5'b00000,
        OPC_SUB = 5'b00001,
        OPC_MUL = 5'b00010,
        OPC_HLT = 5'b11111
    } opcode_e;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_SUB  = 2'd1,
        ALU_MUL  = 2'd2,
        ALU_NONE = 2'd3
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_e;

endpackage

// File: rtl/gpp16_decode.sv
// Combinational instruction decode: splits IR into register fields and classifies the opcode.
module gpp16_decode
    import gpp16_pkg::*;
(
    input  logic [INSTR_W-1:0] ir,
    output logic [1:0]         alu_op,
    output logic [2:0]         rd,
    output logic [2:0]         rs1,
    output logic [2:0]         rs2,
    output logic               is_hlt,
    output logic               is_illegal
);

    logic [4:0] opc;
    logic       unused_bits;

    assign opc         = ir[OPC_MSB:OPC_LSB];
    assign rd          = ir[RD_MSB:RD_LSB];
    assign rs1         = ir[RS1_MSB:RS1_LSB];
    assign rs2         = ir[RS2_MSB:RS2_LSB];
    assign unused_bits = ^ir[1:0];

    always_comb begin
        alu_op     = ALU_NONE;
        is_hlt     = 1'b0;
        is_illegal = 1'b0;
        case (opc)
            OPC_ADD: alu_op = ALU_ADD;
            OPC_SUB: alu_op = ALU_SUB;
            OPC_MUL: alu_op = ALU_MUL;
            OPC_HLT: is_hlt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/gpp16_seq_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/WB sequencer: owns pc, IR, MUL cycle counter, retire count and sticky illegal flag.
// Stall freezes every active state; start is only honoured in IDLE and (when no illegal opcode was seen) HALT.
module gpp16_seq_ctrl
    import gpp16_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          MUL_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stall,
    input  logic [INSTR_W-1:0] instr,
    output logic [15:0]        pc,
    output logic [1:0]         alu_op,
    output logic [2:0]         rd,
    output logic [2:0]         rs1,
    output logic [2:0]         rs2,
    output logic               rf_we,
    output logic               busy,
    output logic               halted,
    output logic               illegal,
    output logic [15:0]        retired
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

    state_e               state;
    logic [INSTR_W-1:0]   ir;
    logic [CNT_W-1:0]     cnt;

    logic [1:0]           dec_alu_op;
    logic [2:0]           dec_rd;
    logic [2:0]           dec_rs1;
    logic [2:0]           dec_rs2;
    logic                 dec_hlt;
    logic                 dec_illegal;
    logic                 in_exec_wb;

    gpp16_decode u_decode (
        .ir         (ir),
        .alu_op     (dec_alu_op),
        .rd         (dec_rd),
        .rs1        (dec_rs1),
        .rs2        (dec_rs2),
        .is_hlt     (dec_hlt),
        .is_illegal (dec_illegal)
    );

    // Status outputs decode straight from state so an async reset clears them in the same cycle.
    assign in_exec_wb = (state == ST_EXEC) || (state == ST_WB);
    assign busy       = (state == ST_FETCH) || (state == ST_DECODE) || in_exec_wb;
    assign halted     = (state == ST_HALT);
    assign rf_we      = (state == ST_WB) && !stall;
    assign alu_op     = in_exec_wb ? dec_alu_op : ALU_NONE;
    assign rd         = in_exec_wb ? dec_rd  : 3'd0;
    assign rs1        = in_exec_wb ? dec_rs1 : 3'd0;
    assign rs2        = in_exec_wb ? dec_rs2 : 3'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pc      <= RESET_PC;
            ir      <= '0;
            cnt     <= '0;
            retired <= '0;
            illegal <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (!stall) begin
                        ir    <= instr;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (!stall) begin
                        if (dec_illegal) begin
                            illegal <= 1'b1;
                            state   <= ST_HALT;
                        end else if (dec_hlt) begin
                            pc    <= pc + 16'd1;
                            state <= ST_HALT;
                        end else begin
                            cnt   <= (dec_alu_op == ALU_MUL) ? MUL_LOAD : '0;
                            state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (!stall) begin
                        if (cnt == '0) state <= ST_WB;
                        else           cnt   <= cnt - 1'b1;
                    end
                end
                ST_WB: begin
                    if (!stall) begin
                        pc      <= pc + 16'd1;
                        retired <= retired + 16'd1;
                        state   <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    // An illegal opcode locks the core here until reset.
                    if (start && !illegal) state <= ST_FETCH;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpp16_seq_ctrl.sv
// Scoreboard bench for gpp16_seq_ctrl: a program-level model predicts write-backs, halt cycle and final state.
module tb_gpp16_seq_ctrl;

    localparam int MULC = 3;
    localparam int MAXC = 250;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [1:0]  alu_op;
    logic [2:0]  rd, rs1, rs2;
    logic        rf_we, busy, halted, illegal;
    logic [15:0] retired;

    logic        start_w = 1'b0;
    logic        stall_w = 1'b0;
    logic [15:0] instr_w;
    logic [15:0] pc_w;
    logic [1:0]  alu_op_w;
    logic [2:0]  rd_w, rs1_w, rs2_w;
    logic        rf_we_w, busy_w, halted_w, illegal_w;
    logic [15:0] retired_w;

    logic [15:0] rom [0:255];
    logic        stall_tab [0:255];
    logic [15:0] pc_log [0:255];

    typedef struct {
        int rd;
        int rs1;
        int rs2;
        int op;
        int pc;
        int ret;
        int cyc;
    } wb_t;
    wb_t sb[$];

    int cyc = 0;
    int base = 0;
    bit running = 1'b0;
    int n_cmp = 0;
    int n_err = 0;

    gpp16_seq_ctrl #(.RESET_PC(16'h0000), .MUL_CYCLES(MULC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .instr(instr),
        .pc(pc), .alu_op(alu_op), .rd(rd), .rs1(rs1), .rs2(rs2), .rf_we(rf_we),
        .busy(busy), .halted(halted), .illegal(illegal), .retired(retired)
    );

    gpp16_seq_ctrl #(.RESET_PC(16'hFFFF), .MUL_CYCLES(MULC)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(start_w), .stall(stall_w), .instr(instr_w),
        .pc(pc_w), .alu_op(alu_op_w), .rd(rd_w), .rs1(rs1_w), .rs2(rs2_w), .rf_we(rf_we_w),
        .busy(busy_w), .halted(halted_w), .illegal(illegal_w), .retired(retired_w)
    );

    assign instr   = rom[pc[7:0]];
    assign instr_w = (pc_w == 16'hFFFF) ? {5'b00000, 3'd1, 3'd2, 3'd3, 2'b00} : 16'hF800;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk(input logic [4:0] op, input int r_d, input int r_1, input int r_2);
        return {op, 3'(r_d), 3'(r_1), 3'(r_2), 2'b00};
    endfunction

    // Monitor: every write strobe must match the oldest predicted write-back.
    initial begin
        forever begin
            @(negedge clk);
            if (running && (cyc - base + 1) >= 0 && (cyc - base + 1) < 256)
                pc_log[cyc - base + 1] = pc;
            if (rf_we) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rf_we", 1, 0);
                end else begin
                    wb_t e;
                    e = sb.pop_front();
                    chk("wb_rd", rd, e.rd);
                    chk("wb_rs1", rs1, e.rs1);
                    chk("wb_rs2", rs2, e.rs2);
                    chk("wb_alu_op", alu_op, e.op);
                    chk("wb_pc", pc, e.pc);
                    chk("wb_retired", retired, e.ret);
                    chk("wb_cycle", cyc - base + 1, e.cyc);
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        sb.delete();
        running = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) begin
            rom[i]       = 16'hF800;
            stall_tab[i] = 1'b0;
        end
    endtask

    // Program-level model: each instruction needs a fixed number of unstalled active cycles.
    task automatic model(output int exp_halt, output int exp_pc, output int exp_ret, output int exp_ill);
        int t, addr, ret, c, n, need;
        logic [15:0] w;
        t = 1; addr = 0; ret = 0;
        exp_halt = -1; exp_ill = 0;
        while (t < MAXC) begin
            w = rom[addr[7:0]];
            if (w[15:11] == 5'b00000 || w[15:11] == 5'b00001) need = 4;
            else if (w[15:11] == 5'b00010) need = 3 + MULC;
            else need = 2;
            c = t; n = 0;
            while (c < MAXC) begin
                if (!stall_tab[c]) n++;
                if (n == need) break;
                c++;
            end
            if (need != 2) begin
                wb_t e;
                e.rd = int'(w[10:8]); e.rs1 = int'(w[7:5]); e.rs2 = int'(w[4:2]);
                e.op = (w[15:11] == 5'b00000) ? 0 : (w[15:11] == 5'b00001) ? 1 : 2;
                e.pc = addr; e.ret = ret; e.cyc = c;
                sb.push_back(e);
                ret++; addr++; t = c + 1;
            end else begin
                if (w[15:11] == 5'b11111) addr++;
                else exp_ill = 1;
                exp_halt = c + 1;
                break;
            end
        end
        exp_pc = addr;
        exp_ret = ret;
    endtask

    task automatic run_prog(input int abort_c, output int halt_c);
        int exp_halt, exp_pc, exp_ret, exp_ill;
        model(exp_halt, exp_pc, exp_ret, exp_ill);
        halt_c = -1;
        @(posedge clk);
        #1;
        start = 1'b1;
        stall = stall_tab[0];
        base = cyc + 1;
        running = 1'b1;
        for (int c = 1; c < MAXC; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            stall = stall_tab[c];
            if (c == abort_c) begin
                rst_n = 1'b0;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_rf_we", rf_we, 0);
                chk("rst_pc", pc, 0);
                chk("rst_retired", retired, 0);
                sb.delete();
                running = 1'b0;
                stall = 1'b0;
                return;
            end
            if (halted) begin
                halt_c = c;
                break;
            end
        end
        running = 1'b0;
        stall = 1'b0;
        chk("halt_cycle", halt_c, exp_halt);
        chk("halt_pc", pc, exp_pc);
        chk("halt_retired", retired, exp_ret);
        chk("halt_illegal", illegal, exp_ill);
        chk("sb_drained", sb.size(), 0);
    endtask

    task automatic load_plan();
        clear_prog();
        rom[0] = mk(5'b00000, 1, 2, 3);
        rom[1] = mk(5'b00001, 4, 1, 2);
        rom[2] = mk(5'b00010, 5, 1, 1);
        rom[3] = 16'hF800;
        rom[4] = mk(5'b00000, 6, 6, 6);
    endtask

    initial begin
        int hc;
        clear_prog();
        #2;
        chk("reset_pc", pc, 0);
        chk("reset_alu_op", alu_op, 3);
        chk("reset_rf_we", rf_we, 0);
        chk("reset_busy", busy, 0);
        chk("reset_halted", halted, 0);
        chk("reset_illegal", illegal, 0);
        chk("reset_retired", retired, 0);
        chk("reset_rd", rd, 0);
        do_reset();

        // Reference program, no stall, then restart after HLT.
        load_plan();
        run_prog(-1, hc);
        chk("plan_halt_cycle", hc, 17);
        chk("plan_pc", pc, 4);
        chk("plan_retired", retired, 3);
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk("restart_busy", busy, 1);
        chk("restart_pc", pc, 4);
        do_reset();
        chk("after_reset_illegal", illegal, 0);
        chk("after_reset_pc", pc, 0);

        // Same program with a 5-cycle stall inside MUL EXEC.
        load_plan();
        for (int c = 11; c <= 15; c++) stall_tab[c] = 1'b1;
        run_prog(-1, hc);
        chk("stall_halt_cycle", hc, 22);
        chk("stall_pc_c11", pc_log[11], 2);
        chk("stall_pc_c15", pc_log[15], 2);
        do_reset();

        // Illegal opcode locks the core in HALT.
        clear_prog();
        rom[0] = mk(5'b00011, 1, 1, 1);
        run_prog(-1, hc);
        chk("ill_pc", pc, 0);
        chk("ill_flag", illegal, 1);
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        chk("ill_still_halted", halted, 1);
        chk("ill_not_busy", busy, 0);
        do_reset();

        // Reset in the middle of MUL EXEC.
        load_plan();
        run_prog(12, hc);
        do_reset();

        // Random programs with random stalls.
        for (int p = 0; p < 25; p++) begin
            int len;
            clear_prog();
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                logic [4:0] op;
                if ($urandom_range(0, 9) == 0) op = 5'($urandom_range(3, 30));
                else op = 5'($urandom_range(0, 2));
                rom[i] = {op, 11'($urandom)};
            end
            for (int c = 0; c < 256; c++) stall_tab[c] = ($urandom_range(0, 3) == 0);
            run_prog(-1, hc);
            do_reset();
        end

        // pc wrap from 0xFFFF.
        @(posedge clk); #1; start_w = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1; start_w = 1'b0;
            if (c == 4) begin
                chk("wrap_rf_we", rf_we_w, 1);
                chk("wrap_wb_pc", pc_w, 16'hFFFF);
            end
            if (c == 5) begin
                chk("wrap_pc", pc_w, 0);
                chk("wrap_retired", retired_w, 1);
            end
            if (c == 7) chk("wrap_halted", halted_w, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/gpp16_seq_ctrl.md
# gpp16_seq_ctrl

Multicycle sequencer for the GPP16 core. Owns the program counter, drives the instruction-memory address, latches the returned word into an instruction register, and decodes the 5-bit opcode. It steps each instruction through FETCH/DECODE/EXEC/WB and issues register-file write strobes and ALU controls. It sits between the combinational instruction ROM and the ALU/register-file datapath, and supports stall, halt and restart.

## Interface
- RESET_PC, 16'h0000: PC value after reset.
- MUL_CYCLES, 3: EXEC cycles for MUL; legal range ≥1.
- One clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin or resume execution; sampled in IDLE and HALT only.
- stall  in  1  freezes the sequencer in FETCH/DECODE/EXEC/WB.
- instr  in  16  instruction word from ROM, combinational on pc.
- pc  out  16  instruction address to ROM.
- alu_op  out  2  0=ADD, 1=SUB, 2=MUL, 3=none.
- rd, rs1, rs2  out  3 each  register fields of IR.
- rf_we  out  1  one-cycle register-file write strobe.
- busy  out  1  high in FETCH, DECODE, EXEC and WB.
- halted  out  1  high in HALT.
- illegal  out  1  sticky illegal-opcode flag.
- retired  out  16  count of instructions written back; wraps.

## Operation
- Instruction fields:
  - opcode = [15:11], rd = [10:8], rs1 = [7:5], rs2 = [4:2]; [1:0] ignored.
  - Opcodes: ADD=00000, SUB=00001, MUL=00010, HLT=11111. All others are illegal.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: start=1 → FETCH.
- FETCH: IR ← instr (addressed by pc) → DECODE.
- DECODE:
  - ADD/SUB: → EXEC, counter ← 0.
  - MUL: → EXEC, counter ← MUL_CYCLES−1.
  - HLT: pc ← pc+1 → HALT.
  - Illegal: illegal ← 1, pc unchanged → HALT.
- EXEC: if counter=0 → WB; otherwise counter decrements and the state holds.
- WB: rf_we=1, pc ← pc+1 (16-bit, 0xFFFF wraps to 0x0000), retired ← retired+1 → FETCH.
- HALT:
  - start=1 with illegal=0 → FETCH at the current pc.
  - start is ignored while illegal=1; only reset clears the flag.
- Outputs:
  - alu_op, rd, rs1 and rs2 decode from IR and are valid in EXEC and WB.
  - alu_op=3 in all other states.
- stall=1 in an active state freezes state, pc, IR, counter and retired. rf_we is forced to 0 while stalled in WB.
- stall has no effect in IDLE or HALT. start and stall asserted together in IDLE still go to FETCH.
- start outside IDLE/HALT is ignored.

## Timing
- Reset values: state IDLE, pc=RESET_PC, IR=0, counter=0, retired=0, illegal=0. All outputs 0 except alu_op=3.
- Reset takes effect immediately, including mid-instruction; no partial write-back.
- Latency:
  - start sampled at edge N → FETCH in cycle N+1.
  - ADD/SUB: 4 cycles per instruction.
  - MUL: 3+MUL_CYCLES cycles.
  - HLT: 2 cycles, then HALT.
- rf_we is high for exactly one unstalled WB cycle.
- pc, retired and illegal update on the edge that leaves the state.
- instr must be stable during FETCH; the ROM is combinational, so no wait states.

## Structure
- Package gpp16_pkg holds:
  - opcode enum;
  - state enum;
  - alu_op encoding;
  - field bit-position constants;
  - instruction-width constant (16).
- One combinational sub-module, gpp16_decode: IR → alu_op, rd/rs1/rs2, is_hlt, is_illegal.
- Registers and the FSM stay in gpp16_seq_ctrl.

## Test plan
- ROM {ADD R1,R2,R3; SUB R4,R1,R2; MUL R5,R1,R1; HLT}, start at edge 0 → rf_we in cycles 4, 8 and 14 with (rd,rs1,rs2,alu_op) = (1,2,3,0), (4,1,2,1), (5,1,1,2). halted=1 from cycle 17, pc=4, retired=3.
- Same program, stall=1 for 5 cycles during MUL EXEC → MUL rf_we moves to cycle 19, pc stays 2 throughout the stall, halted from cycle 22.
- instr opcode 00011 at pc 0 → halted=1, illegal=1, pc=0, rf_we never asserts. A later start pulse leaves halted=1.
- After HLT at pc 3, pulse start → FETCH at pc=4 next cycle. Reset → illegal=0, pc=RESET_PC.
- rst_n low during MUL EXEC → same cycle: busy=0, rf_we=0, pc=0, retired=0. No write-back occurs.
- RESET_PC=16'hFFFF, ADD at that address → after WB pc=16'h0000, retired=1.
